timeout_multi: RTL and testbench

TIMEOUT_MULTI -- requirements
Module: timeout_multi

---
 rtl/timeout_multi.sv | 92 +++++++++
 tb/tb_timeout_multi.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timeout_multi.sv
`default_nettype none
// ============================================================================
// Module   : timeout_multi
// Purpose  : Bank of independent countdown timers sharing one tick prescaler,
//            with one-shot / auto-reload modes and one-cycle expiry pulses.
// Revision : 1.0 - initial release
// ============================================================================
module timeout_multi #(
  parameter int CHANNELS       = 4,
  parameter int COUNTER_WIDTH  = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                              clk_in,
  input  logic                              reset_n,
  input  logic [PRESCALE_WIDTH-1:0]         prescale,
  input  logic [CHANNELS-1:0]               start,
  input  logic [CHANNELS-1:0]               cancel,
  input  logic [CHANNELS-1:0]               periodic,
  input  logic [CHANNELS*COUNTER_WIDTH-1:0] value,
  output logic [CHANNELS*COUNTER_WIDTH-1:0] counter,
  output logic [CHANNELS-1:0]               running,
  output logic [CHANNELS-1:0]               expired,
  output logic                              any_running
);

  localparam logic [COUNTER_WIDTH-1:0]  c_cnt_one = COUNTER_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] c_pre_one = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] r_pre_cnt;
  logic                      w_tick;

  // Using >= means a prescale drop below the current count ticks at once
  // instead of wrapping through the full range.
  assign w_tick = (r_pre_cnt >= prescale);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + c_pre_one;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [COUNTER_WIDTH-1:0] r_count;
    logic [COUNTER_WIDTH-1:0] r_reload;
    logic                     r_mode;
    logic                     r_start_q;
    logic                     r_expired;
    logic                     w_start_edge;
    logic [COUNTER_WIDTH-1:0] w_load;

    assign w_load       = value[i*COUNTER_WIDTH +: COUNTER_WIDTH];
    assign w_start_edge = start[i] & ~r_start_q;

    // Priority: cancel, start edge, tick decrement, hold.
    always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
        r_count   <= '0;
        r_reload  <= '0;
        r_mode    <= 1'b0;
        r_start_q <= 1'b0;
        r_expired <= 1'b0;
      end else begin
        r_start_q <= start[i];
        r_expired <= 1'b0;
        if (cancel[i]) begin
          r_count <= '0;
        end else if (w_start_edge) begin
          r_count  <= w_load;
          r_reload <= w_load;
          r_mode   <= periodic[i];
        end else if (w_tick && (r_count == c_cnt_one)) begin
          r_expired <= 1'b1;
          r_count   <= r_mode ? r_reload : '0;
        end else if (w_tick && (r_count > c_cnt_one)) begin
          r_count <= r_count - c_cnt_one;
        end
      end
    end

    assign counter[i*COUNTER_WIDTH +: COUNTER_WIDTH] = r_count;
    assign running[i] = |r_count;
    assign expired[i] = r_expired;
  end

  assign any_running = |running;

endmodule
`default_nettype wire

// File: tb/tb_timeout_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_timeout_multi
// Purpose  : Self-checking bench for timeout_multi: directed table, corner
//            sequences and randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timeout_multi;

  localparam int CH = 4;
  localparam int CW = 8;
  localparam int PW = 8;

  logic             clk_in = 1'b0;
  logic             reset_n;
  logic [PW-1:0]    prescale;
  logic [CH-1:0]    start, cancel, periodic;
  logic [CH*CW-1:0] value;
  logic [CH*CW-1:0] counter;
  logic [CH-1:0]    running, expired;
  logic             any_running;

  int checks = 0;
  int errors = 0;

  timeout_multi #(.CHANNELS(CH), .COUNTER_WIDTH(CW), .PRESCALE_WIDTH(PW)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .prescale(prescale),
    .start(start), .cancel(cancel), .periodic(periodic), .value(value),
    .counter(counter), .running(running), .expired(expired),
    .any_running(any_running)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural reference: integer timers advanced by the published rules.
  int  m_cycles_since_tick;
  int  m_left [CH];
  int  m_reload [CH];
  bit  m_auto [CH];
  bit  m_prev_start [CH];
  bit  m_pulse [CH];
  bit  m_tick;
  bit  m_rise;

  always @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      m_cycles_since_tick = 0;
      for (int i = 0; i < CH; i++) begin
        m_left[i] = 0; m_reload[i] = 0; m_auto[i] = 0;
        m_prev_start[i] = 0; m_pulse[i] = 0;
      end
    end else begin
      m_tick = (m_cycles_since_tick >= int'(prescale));
      for (int i = 0; i < CH; i++) begin
        m_rise = start[i] && !m_prev_start[i];
        m_prev_start[i] = start[i];
        m_pulse[i] = 0;
        if (cancel[i]) m_left[i] = 0;
        else if (m_rise) begin
          m_left[i]   = int'(value[i*CW +: CW]);
          m_reload[i] = m_left[i];
          m_auto[i]   = periodic[i];
        end else if (m_tick && m_left[i] > 0) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_pulse[i] = 1;
            if (m_auto[i]) m_left[i] = m_reload[i];
          end
        end
      end
      m_cycles_since_tick = m_tick ? 0 : m_cycles_since_tick + 1;
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_model();
    logic [CH*CW-1:0] mc;
    logic [CH-1:0]    mr, me;
    for (int i = 0; i < CH; i++) begin
      mc[i*CW +: CW] = CW'(m_left[i]);
      mr[i] = (m_left[i] != 0);
      me[i] = m_pulse[i];
    end
    chk("model_counter", counter, mc);
    chk("model_running", running, mr);
    chk("model_expired", expired, me);
    chk("model_any_running", any_running, |mr);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       st;
    logic       cn;
    logic [7:0] val;
    int         cnt;
    logic       ex;
    logic       run;
  } vec_t;

  vec_t vecs [12];
  int   pulse_t [3];
  int   np;
  int   cyc;
  bit   found;

  initial begin
    reset_n = 1'b0; prescale = '0; start = '0; cancel = '0;
    periodic = '0; value = '0;
    repeat (3) @(posedge clk_in);
    #1 reset_n = 1'b1;
    chk("reset_counter", counter, 0);
    chk("reset_running", running, 0);
    chk("reset_expired", expired, 0);
    chk("reset_any", any_running, 0);
    step();

    // Channel 0, prescale 0: one-shot countdown, then cancel-vs-start corners.
    vecs[0]  = '{1'b1, 1'b0, 8'd5, 5, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 8'd5, 4, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 8'd5, 3, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 8'd5, 2, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 8'd5, 1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'd5, 0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'd5, 0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 8'd9, 0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'd9, 0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'd2, 0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'd2, 2, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 8'd2, 0, 1'b0, 1'b0};
    for (int k = 0; k < 12; k++) begin
      start[0] = vecs[k].st; cancel[0] = vecs[k].cn; value[7:0] = vecs[k].val;
      step();
      chk($sformatf("vec%0d_counter0", k), counter[7:0], vecs[k].cnt);
      chk($sformatf("vec%0d_expired0", k), expired[0], vecs[k].ex);
      chk($sformatf("vec%0d_running0", k), running[0], vecs[k].run);
    end
    start = '0; cancel = '0;
    step();

    // Channel 1 periodic at prescale 3: pulses every 8 cycles until cancel.
    prescale = 8'd3; periodic[1] = 1'b1; value[15:8] = 8'd2; start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    np = 0; cyc = 0;
    while (np < 3 && cyc < 100) begin
      step(); cyc++;
      if (expired[1]) begin
        pulse_t[np] = cyc; np++;
        chk("periodic_reload", counter[15:8], 2);
      end
    end
    chk("periodic_pulse_count", np, 3);
    if (np == 3) begin
      chk("periodic_gap1", pulse_t[1] - pulse_t[0], 8);
      chk("periodic_gap2", pulse_t[2] - pulse_t[1], 8);
    end
    cancel[1] = 1'b1; step(); cancel[1] = 1'b0;
    np = 0;
    repeat (30) begin step(); if (expired[1]) np++; end
    chk("after_cancel_pulses", np, 0);
    chk("after_cancel_counter1", counter[15:8], 0);

    // Channel 2 restart at counter 4 with a new value.
    prescale = 8'd0; periodic = '0; value[23:16] = 8'd10; start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (counter[23:16] == 8'd4) found = 1; else step();
    end
    chk("restart_reached4", found, 1);
    value[23:16] = 8'd3; start[2] = 1'b1;
    step();
    chk("restart_counter2", counter[23:16], 3);
    chk("restart_no_expiry", expired[2], 0);
    start[2] = 1'b0;

    // Channel 3: start edge on the expiring tick wins; zero value stays idle.
    value[31:24] = 8'd2; start[3] = 1'b1;
    step();
    start[3] = 1'b0;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (counter[31:24] == 8'd1) found = 1; else step();
    end
    chk("edge_tick_reached1", found, 1);
    value[31:24] = 8'd7; start[3] = 1'b1;
    step();
    chk("edge_tick_counter3", counter[31:24], 7);
    chk("edge_tick_no_expiry", expired[3], 0);
    start[3] = 1'b0; cancel[3] = 1'b1;
    step();
    cancel[3] = 1'b0; value[31:24] = 8'd0; start[3] = 1'b1;
    step();
    chk("zero_value_running3", running[3], 0);
    chk("zero_value_expired3", expired[3], 0);
    start = '0;
    repeat (12) step();

    // Asynchronous reset mid-count, start held across release.
    prescale = 8'd3; value = {8'd0, 8'd0, 8'd20, 8'd50}; start[1:0] = 2'b11;
    repeat (6) step();
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_counter", counter, 0);
    chk("async_reset_expired", expired, 0);
    chk("async_reset_any", any_running, 0);
    value[7:0] = 8'd6; start[1] = 1'b0;
    @(posedge clk_in);
    #3 reset_n = 1'b1;
    repeat (3) step();
    chk("held_start_counter0", counter[7:0], 6);
    step();
    chk("prescaler_restart_counter0", counter[7:0], 5);
    start = '0;

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 5) == 0) start[i] = ~start[i];
        cancel[i]   = ($urandom_range(0, 24) == 0);
        periodic[i] = $urandom_range(0, 1);
        value[i*CW +: CW] = CW'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 31) == 0) prescale = PW'($urandom_range(0, 4));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
